// File: rtl/conv_filt_pkg.sv
// rtl/conv_filt_pkg.sv - shared constants and types for the 5x5 convolution filter
package conv_filt_pkg;
  localparam int COEF_W     = 8;
  localparam int SHIFT      = 4;
  localparam int LAT        = 7;
  localparam int NTAP       = 25;
  localparam int CENTER_TAP = 12;
  localparam int DE         = 0;
  localparam int HS         = 1;
  localparam int VS         = 2;
  localparam int PROD_W     = 17;
  localparam int SUM_W      = 22;

  typedef logic [COEF_W-1:0]       coef_t;
  typedef coef_t [NTAP-1:0]        coef_arr_t;
  typedef logic [7:0]              chan_t;
  typedef chan_t [NTAP-1:0]        chan_win_t;

  function automatic coef_arr_t ident_kernel();
    coef_arr_t k;
    k = '0;
    k[CENTER_TAP] = coef_t'(1 << SHIFT);
    return k;
  endfunction

  localparam coef_arr_t COEF_IDENT = ident_kernel();
endpackage

// File: rtl/conv_filt_5x5_if.sv
// rtl/conv_filt_5x5_if.sv - row taps, status, coefficient port and filtered output
interface conv_filt_5x5_if;
  import conv_filt_pkg::*;

  logic [23:0]       pa, pb, pc, pd, pe;
  logic [2:0]        stat_in;
  logic              coef_we;
  logic [4:0]        coef_addr;
  logic [COEF_W-1:0] coef_data;
  logic [23:0]       dout;
  logic [2:0]        stat_o;

  modport master (
    output pa, pb, pc, pd, pe, stat_in, coef_we, coef_addr, coef_data,
    input  dout, stat_o
  );

  modport slave (
    input  pa, pb, pc, pd, pe, stat_in, coef_we, coef_addr, coef_data,
    output dout, stat_o
  );
endinterface

// File: rtl/conv_chan_mac.sv
// rtl/conv_chan_mac.sv - one colour channel: 25 products, adder tree, shift/clamp, bypass mux
module conv_chan_mac
  import conv_filt_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  input  chan_win_t i_win,
  input  coef_arr_t i_coef,
  input  logic      i_bypass,
  input  logic      i_cde,
  output chan_t     o_pix
);
  logic signed [PROD_W-1:0] r_prod [NTAP];
  logic signed [SUM_W-1:0]  r_row  [5];
  logic signed [SUM_W-1:0]  r_total;
  chan_t [2:0]              r_ctr;
  logic [2:0]               r_byp;
  logic [2:0]               r_cde;

  logic signed [SUM_W-1:0]  w_row [5];
  logic signed [SUM_W-1:0]  w_total;
  logic signed [SUM_W-1:0]  w_shr;
  chan_t                    w_clamp;

  always_comb begin
    for (int r = 0; r < 5; r++) begin
      w_row[r] = '0;
      for (int c = 0; c < 5; c++) begin
        w_row[r] = w_row[r] + SUM_W'(r_prod[r*5+c]);
      end
    end
    w_total = '0;
    for (int r = 0; r < 5; r++) begin
      w_total = w_total + r_row[r];
    end
    w_shr = r_total >>> SHIFT;
    if (w_shr < 0)        w_clamp = 8'h00;
    else if (w_shr > 255) w_clamp = 8'hFF;
    else                  w_clamp = w_shr[7:0];
  end

  // centre pixel, bypass and centre-de ride alongside the E4..E6 arithmetic
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int t = 0; t < NTAP; t++) r_prod[t] <= '0;
      for (int r = 0; r < 5; r++)    r_row[r]  <= '0;
      r_total <= '0;
      r_ctr   <= '0;
      r_byp   <= '0;
      r_cde   <= '0;
      o_pix   <= '0;
    end else begin
      for (int t = 0; t < NTAP; t++) begin
        r_prod[t] <= PROD_W'($signed({1'b0, i_win[t]})) * PROD_W'($signed(i_coef[t]));
      end
      for (int r = 0; r < 5; r++) r_row[r] <= w_row[r];
      r_total <= w_total;
      r_ctr   <= {r_ctr[1:0], i_win[CENTER_TAP]};
      r_byp   <= {r_byp[1:0], i_bypass};
      r_cde   <= {r_cde[1:0], i_cde};
      if (!r_cde[2])     o_pix <= '0;
      else if (r_byp[2]) o_pix <= r_ctr[2];
      else               o_pix <= w_clamp;
    end
  end
endmodule

// File: rtl/conv_filt_5x5.sv
// rtl/conv_filt_5x5.sv - 5x5 window, de history, double-buffered kernel and stat delay
module conv_filt_5x5
  import conv_filt_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  conv_filt_5x5_if.slave  bus
);
  logic [4:0][4:0][23:0] r_win;
  logic [4:0]            r_de;
  coef_arr_t             r_shadow;
  coef_arr_t             r_active;
  logic                  r_vs_prev;
  logic [LAT-1:0][2:0]   r_stat;

  logic [4:0][23:0]      w_col;
  logic                  w_vs_rise;
  logic                  w_bypass;
  chan_win_t [2:0]       w_win;
  chan_t [2:0]           w_out;

  assign w_col     = {bus.pe, bus.pd, bus.pc, bus.pb, bus.pa};
  assign w_vs_rise = bus.stat_in[VS] & ~r_vs_prev;
  assign w_bypass  = ~&r_de;

  // window is [row][col]; col 0 holds the newest column
  always_comb begin
    w_win = '0;
    for (int ch = 0; ch < 3; ch++) begin
      for (int r = 0; r < 5; r++) begin
        for (int c = 0; c < 5; c++) begin
          w_win[ch][r*5+c] = r_win[r][c][ch*8 +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_win     <= '0;
      r_de      <= '0;
      r_shadow  <= COEF_IDENT;
      r_active  <= COEF_IDENT;
      r_vs_prev <= 1'b0;
      r_stat    <= '0;
    end else begin
      for (int r = 0; r < 5; r++) r_win[r] <= {r_win[r][3:0], w_col[r]};
      r_de      <= {r_de[3:0], bus.stat_in[DE]};
      r_vs_prev <= bus.stat_in[VS];
      r_stat    <= {r_stat[LAT-2:0], bus.stat_in};
      // nonblocking copy sees the pre-write shadow on a coincident write
      if (w_vs_rise) r_active <= r_shadow;
      if (bus.coef_we && (bus.coef_addr < 5'(NTAP))) r_shadow[bus.coef_addr] <= bus.coef_data;
    end
  end

  for (genvar ch = 0; ch < 3; ch++) begin : g_chan
    conv_chan_mac u_mac (
      .clk      (clk),
      .rst      (rst),
      .i_win    (w_win[ch]),
      .i_coef   (r_active),
      .i_bypass (w_bypass),
      .i_cde    (r_de[2]),
      .o_pix    (w_out[ch])
    );
  end

  assign bus.dout   = w_out;
  assign bus.stat_o = r_stat[LAT-1];
endmodule

// File: tb/tb_conv_filt_5x5.sv
// tb/tb_conv_filt_5x5.sv - scenario bench for conv_filt_5x5 against a column-level reference model
module tb_conv_filt_5x5;
  localparam int MAXE = 1024;
  localparam int SH   = 4;

  logic clk;
  logic rst;
  conv_filt_5x5_if bus ();

  conv_filt_5x5 dut (.clk(clk), .rst(rst), .bus(bus));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  logic [23:0] h_pix   [MAXE][5];
  logic [2:0]  h_stat  [MAXE];
  bit          h_rst   [MAXE];
  int          act_hist[MAXE][25];
  int          shadow[25];
  int          act[25];
  bit          prev_vs;
  int          n_edge, cur, n_chk, n_pass;

  // one clock: record what was presented, advance the kernel-bank model, sample 1ns later
  task automatic tick();
    @(posedge clk);
    if (n_edge >= MAXE) begin
      $display("FAIL edge_budget: got %0d edges, limit %0d", n_edge, MAXE);
      $fatal(1);
    end
    cur = n_edge;
    n_edge++;
    for (int t = 0; t < 25; t++) act_hist[cur][t] = act[t];
    h_pix[cur][0] = bus.pa; h_pix[cur][1] = bus.pb; h_pix[cur][2] = bus.pc;
    h_pix[cur][3] = bus.pd; h_pix[cur][4] = bus.pe;
    h_stat[cur] = bus.stat_in;
    h_rst[cur]  = rst;
    if (rst) begin
      for (int t = 0; t < 25; t++) begin
        shadow[t] = (t == 12) ? 16 : 0;
        act[t]    = shadow[t];
      end
      prev_vs = 1'b0;
    end else begin
      if (bus.stat_in[2] && !prev_vs) act = shadow;
      if (bus.coef_we && bus.coef_addr < 25) shadow[bus.coef_addr] = int'($signed(bus.coef_data));
      prev_vs = bus.stat_in[2];
    end
    #1;
  endtask

  function automatic logic [23:0] exp_dout(int i);
    int lr, k, s;
    bit de[5];
    bit all_de;
    logic [23:0] res;
    for (int r = i - 3; r <= i; r++) if (r >= 0 && h_rst[r]) return 24'h0;
    lr = -1;
    for (int r = 0; r <= i - 4; r++) if (h_rst[r]) lr = r;
    all_de = 1'b1;
    for (int j = 0; j < 5; j++) begin
      k = i - 4 - j;
      de[j] = (k >= 0) && (k > lr) && h_stat[k][0];
      if (!de[j]) all_de = 1'b0;
    end
    if (!de[2]) return 24'h0;
    if (!all_de) return h_pix[i-6][2];
    res = '0;
    for (int ch = 0; ch < 3; ch++) begin
      s = 0;
      for (int r = 0; r < 5; r++)
        for (int j = 0; j < 5; j++)
          s += int'(h_pix[i-4-j][r][ch*8 +: 8]) * act_hist[i-3][r*5+j];
      s = s >>> SH;
      if (s < 0) s = 0;
      if (s > 255) s = 255;
      res[ch*8 +: 8] = 8'(s);
    end
    return res;
  endfunction

  function automatic logic [2:0] exp_stat(int i);
    if (i < 6) return 3'b0;
    for (int r = i - 6; r <= i; r++) if (h_rst[r]) return 3'b0;
    return h_stat[i-6];
  endfunction

  task automatic set_col(input logic [23:0] p, input logic [2:0] st);
    bus.pa = p; bus.pb = p; bus.pc = p; bus.pd = p; bus.pe = p;
    bus.stat_in = st;
  endtask

  task automatic load_kernel(input int k[25]);
    bus.stat_in[2] = 1'b0;
    for (int t = 0; t < 25; t++) begin
      bus.coef_we   = 1'b1;
      bus.coef_addr = 5'(t);
      bus.coef_data = 8'(k[t]);
      tick();
    end
    bus.coef_we = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    set_col(24'h0, 3'b0);
    tick();
    tick();
    rst = 1'b0;
    n_chk++;
    if (bus.dout !== 24'h0 || bus.stat_o !== 3'b0)
      $display("FAIL reset_state: dout=%h stat_o=%b, want 000000/000", bus.dout, bus.stat_o);
    else n_pass++;
  endtask

  task automatic test_identity();
    for (int n = 0; n < 20; n++) begin
      set_col(24'h204060, {1'($urandom_range(1)), 1'($urandom_range(1)), 1'b1});
      tick();
      n_chk++;
      if ({bus.dout, bus.stat_o} !== {exp_dout(cur), exp_stat(cur)})
        $display("FAIL identity e%0d: dout=%h stat=%b, want %h/%b", cur, bus.dout, bus.stat_o, exp_dout(cur), exp_stat(cur));
      else n_pass++;
    end
    n_chk++;
    if (bus.dout !== 24'h204060) $display("FAIL identity_const: dout=%h, want 204060", bus.dout);
    else n_pass++;
  endtask

  task automatic test_box();
    int k[25];
    foreach (k[t]) k[t] = 1;
    set_col(24'h101010, 3'b001);
    load_kernel(k);
    for (int n = 0; n < 8; n++) begin
      tick();
      n_chk++;
      if ({bus.dout, bus.stat_o} !== {exp_dout(cur), exp_stat(cur)})
        $display("FAIL box_pre e%0d: dout=%h stat=%b, want %h/%b", cur, bus.dout, bus.stat_o, exp_dout(cur), exp_stat(cur));
      else n_pass++;
    end
    n_chk++;
    if (bus.dout !== 24'h101010) $display("FAIL box_shadow_only: dout=%h, want 101010", bus.dout);
    else n_pass++;
    set_col(24'h101010, 3'b101);
    for (int n = 0; n < 10; n++) begin
      tick();
      n_chk++;
      if ({bus.dout, bus.stat_o} !== {exp_dout(cur), exp_stat(cur)})
        $display("FAIL box_post e%0d: dout=%h stat=%b, want %h/%b", cur, bus.dout, bus.stat_o, exp_dout(cur), exp_stat(cur));
      else n_pass++;
    end
    n_chk++;
    if (bus.dout !== 24'h191919) $display("FAIL box_active: dout=%h, want 191919", bus.dout);
    else n_pass++;
  endtask

  task automatic test_clamp();
    int k[25];
    int cv[2];
    logic [23:0] want[2];
    cv[0] = 127;  want[0] = 24'hFF00FF;
    cv[1] = -128; want[1] = 24'h000000;
    for (int ph = 0; ph < 2; ph++) begin
      foreach (k[t]) k[t] = (t == 12) ? cv[ph] : 0;
      set_col(24'hFF00FF, 3'b001);
      load_kernel(k);
      set_col(24'hFF00FF, 3'b101);
      for (int n = 0; n < 10; n++) begin
        tick();
        n_chk++;
        if ({bus.dout, bus.stat_o} !== {exp_dout(cur), exp_stat(cur)})
          $display("FAIL clamp%0d e%0d: dout=%h stat=%b, want %h/%b", ph, cur, bus.dout, bus.stat_o, exp_dout(cur), exp_stat(cur));
        else n_pass++;
      end
      n_chk++;
      if (bus.dout !== want[ph]) $display("FAIL clamp_const%0d: dout=%h, want %h", ph, bus.dout, want[ph]);
      else n_pass++;
    end
  endtask

  task automatic test_borders();
    int k[25];
    int ce1, kk, v;
    logic [23:0] want;
    foreach (k[t]) k[t] = 1;
    set_col(24'h0, 3'b000);
    load_kernel(k);
    set_col(24'h0, 3'b100);
    tick();
    ce1 = -100;
    for (int n = 0; n < 26; n++) begin
      if (n >= 6 && n < 16) set_col(24'h010101 * (n - 5), 3'b101);
      else set_col(24'h0, 3'b100);
      tick();
      if (n == 6) ce1 = cur;
      n_chk++;
      if ({bus.dout, bus.stat_o} !== {exp_dout(cur), exp_stat(cur)})
        $display("FAIL border e%0d: dout=%h stat=%b, want %h/%b", cur, bus.dout, bus.stat_o, exp_dout(cur), exp_stat(cur));
      else n_pass++;
      kk = cur - 6 - ce1 + 1;
      if (kk >= 1 && kk <= 12) begin
        if (kk > 10) v = 0;
        else if (kk <= 2 || kk >= 9) v = kk;
        else v = (25 * kk) >> 4;
        want = 24'h010101 * 24'(v);
        n_chk++;
        if (bus.dout !== want) $display("FAIL border_col%0d: dout=%h, want %h", kk, bus.dout, want);
        else n_pass++;
      end
    end
  endtask

  task automatic test_vs_edge();
    set_col(24'h101010, 3'b001);
    for (int n = 0; n < 3; n++) tick();
    set_col(24'h101010, 3'b101);
    bus.coef_we = 1'b1; bus.coef_addr = 5'd12; bus.coef_data = 8'd32;
    tick();
    bus.coef_we = 1'b0;
    for (int n = 0; n < 10; n++) begin
      tick();
      n_chk++;
      if ({bus.dout, bus.stat_o} !== {exp_dout(cur), exp_stat(cur)})
        $display("FAIL vs_edge e%0d: dout=%h stat=%b, want %h/%b", cur, bus.dout, bus.stat_o, exp_dout(cur), exp_stat(cur));
      else n_pass++;
    end
    n_chk++;
    if (bus.dout !== 24'h191919) $display("FAIL vs_edge_old: dout=%h, want 191919", bus.dout);
    else n_pass++;
    set_col(24'h101010, 3'b001);
    tick();
    set_col(24'h101010, 3'b101);
    for (int n = 0; n < 10; n++) tick();
    n_chk++;
    if (bus.dout !== 24'h383838) $display("FAIL vs_edge_new: dout=%h, want 383838", bus.dout);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    int r_edge;
    for (int n = 0; n < 8; n++) begin
      set_col(24'h102030, {1'b0, 1'($urandom_range(1)), 1'b1});
      tick();
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    r_edge = cur;
    n_chk++;
    if (bus.dout !== 24'h0 || bus.stat_o !== 3'b0)
      $display("FAIL reset_mid_zero: dout=%h stat=%b, want 000000/000", bus.dout, bus.stat_o);
    else n_pass++;
    for (int n = 0; n < 14; n++) begin
      set_col(24'h102030, {1'b0, 1'($urandom_range(1)), 1'b1});
      tick();
      n_chk++;
      if ({bus.dout, bus.stat_o} !== {exp_dout(cur), exp_stat(cur)})
        $display("FAIL reset_mid e%0d: dout=%h stat=%b, want %h/%b", cur, bus.dout, bus.stat_o, exp_dout(cur), exp_stat(cur));
      else n_pass++;
      if (cur == r_edge + 6 || cur == r_edge + 7) begin
        n_chk++;
        if (bus.dout !== ((cur == r_edge + 7) ? 24'h102030 : 24'h0))
          $display("FAIL reset_mid_resume e+%0d: dout=%h", cur - r_edge, bus.dout);
        else n_pass++;
      end
    end
    n_chk++;
    if (bus.dout !== 24'h102030) $display("FAIL reset_mid_ident: dout=%h, want 102030", bus.dout);
    else n_pass++;
  endtask

  task automatic test_random();
    int k[25];
    logic vs;
    foreach (k[t]) k[t] = int'($urandom_range(16)) - 8;
    set_col(24'h0, 3'b001);
    load_kernel(k);
    vs = 1'b1;
    for (int n = 0; n < 120; n++) begin
      if ($urandom_range(9) == 0) vs = ~vs;
      bus.pa = 24'($urandom); bus.pb = 24'($urandom); bus.pc = 24'($urandom);
      bus.pd = 24'($urandom); bus.pe = 24'($urandom);
      bus.stat_in   = {vs, 1'($urandom_range(1)), 1'($urandom_range(9) != 0)};
      bus.coef_we   = ($urandom_range(3) == 0);
      bus.coef_addr = 5'($urandom_range(31));
      bus.coef_data = 8'(int'($urandom_range(16)) - 8);
      tick();
      n_chk++;
      if ({bus.dout, bus.stat_o} !== {exp_dout(cur), exp_stat(cur)})
        $display("FAIL random e%0d: dout=%h stat=%b, want %h/%b", cur, bus.dout, bus.stat_o, exp_dout(cur), exp_stat(cur));
      else n_pass++;
    end
    bus.coef_we = 1'b0;
  endtask

  initial begin
    n_chk = 0; n_pass = 0; n_edge = 0; cur = 0; prev_vs = 1'b0;
    for (int t = 0; t < 25; t++) begin
      shadow[t] = (t == 12) ? 16 : 0;
      act[t]    = shadow[t];
    end
    rst = 1'b1;
    bus.coef_we = 1'b0; bus.coef_addr = '0; bus.coef_data = '0;
    set_col(24'h0, 3'b0);
    test_reset();
    test_identity();
    test_box();
    test_clamp();
    test_borders();
    test_vs_edge();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/conv_filt_5x5.md
Name: conv_filt_5x5

Overview:
- Consumer of the five vertically aligned row taps produced by the line-delay stage in the HDMI convolution filter path.
- Builds a 5x5 pixel window using horizontal shift registers, then applies a programmable signed 5x5 kernel per RGB channel.
- Clamps the result and outputs one filtered 24-bit pixel per clock, with its stat bits kept aligned.
- Coefficients are loaded at run time into a shadow bank and become active only at frame start, so a frame never tears.

Parameters:
- COEF_W, 8: signed coefficient width.
- SHIFT, 4: arithmetic right shift applied to each channel sum (fixed-point fraction bits).

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; synchronous, active-high.
- pa, pb, pc, pd, pe  in  24 each  row taps, pa newest row, pe oldest; {R[23:16], G[15:8], B[7:0]}, unsigned.
- stat_in  in  3  status of the presented column: bit0 = de, bit1 = hs, bit2 = vs.
- coef_we  in  1  coefficient write strobe.
- coef_addr  in  5  tap index = row*5 + col, row 0 = pa, col 0 = newest column; valid range 0..24.
- coef_data  in  COEF_W  signed coefficient.
- dout  out  24  filtered pixel.
- stat_o  out  3  stat_in delayed by LAT = 7 clocks.

Behaviour:
- Clocking: a single clock domain; every register is synchronous to clk.
- Reset:
  - dout, stat_o, all window, pipeline and delay registers go to 0.
  - Both coefficient banks load identity: tap 12 = 1<<SHIFT (16), all other taps 0.
- Window:
  - Each clock, column {pa..pe} is shifted into column 0 and the old column 4 is dropped.
  - A 5-bit de shift register runs in parallel with the columns.
  - The window centre is row 2 (pc), column 2.
- Pipeline, counted in clock edges after a column is presented:
  - E1–E3: the column shifts into the centre position.
  - E4: 25 products per channel are registered. Each is an unsigned 8-bit pixel × signed COEF_W coefficient, giving 17 bits signed.
  - E5: five row sums are registered.
  - E6: the 22-bit signed total is registered.
  - E7: the total is arithmetically shifted right by SHIFT, clamped to 0..255, and dout is registered.
  - LAT = 7, fixed. There is no backpressure; throughput is one pixel per clock.
- Bypass:
  - If any of the 5 de bits in the window is 0 (first 2 / last 2 columns of a line), dout is the unfiltered centre pixel.
  - The bypass flag and the centre pixel are carried through the pipeline with identical latency.
  - If the centre column's de = 0, dout = 0.
  - Vertical borders are not handled here.
- Clamp: a negative result gives 0x00; a result above 255 gives 0xFF. Applied per channel, independently.
- Coefficients:
  - coef_we writes the shadow bank at coef_addr. Writes with addr ≥ 25 are ignored.
  - On the clock where stat_in[2] rises (0→1, relative to the registered previous vs), the whole shadow bank is copied into the active bank.
  - If coef_we and the vs rise occur on the same clock, the copy takes the pre-write shadow contents. The new value lands in shadow and takes effect at the next vs rise.
- stat_o: a plain 7-deep delay of stat_in, independent of the coefficients.
- Reset mid-frame: outputs are 0 from the next clock. Valid output resumes 7 clocks after the first post-reset column, and the window refills naturally. Coefficients return to identity.

Decomposition:
- Package conv_filt_pkg holds:
  - COEF_W, SHIFT, LAT = 7, NTAP = 25, CENTER_TAP = 12.
  - Stat bit indices DE = 0, HS = 1, VS = 2.
  - Product width 17 and sum width 22.
  - The coefficient-array typedef and the identity-kernel constant.
- Sub-module conv_chan_mac: one channel's 25 products, row sums, total, shift/clamp and bypass mux. conv_filt_5x5 instantiates it three times (R, G, B).
- conv_filt_5x5 itself owns:
  - the window shift registers;
  - the de history;
  - the coefficient banks;
  - the stat delay.

Test Plan:
1. Identity after reset: rst for 2 clocks, then all taps = 0x204060, de = 1 for 20 columns, hs/vs toggled → dout = 0x204060 while the window is full; stat_o equals stat_in exactly 7 clocks later.
2. Box kernel load: write taps 0..24 = 1 with no vs rise, all pixels 0x101010 → dout stays 0x101010. After a vs rise, dout = 0x191919 (16×25 = 400, >>4 = 25).
3. Clamp: set tap 12 = 127, all other taps 0, vs rise, pixels 0xFF00FF → dout 0xFF00FF. Set tap 12 = −128, vs rise → dout 0x000000.
4. Line borders: de high for 10 columns with centre values 1..10 per channel, box kernel active → output columns 1, 2, 9, 10 equal the centre pixel unfiltered; columns 3..8 are filtered; de-low columns give dout = 0.
5. Write on the vs edge: coef_we for tap 12 = 32 on the same clock as the vs rise → the old kernel stays active for this frame; the new value takes effect after the next vs rise.
6. Reset mid-line: assert rst for 1 clock while streaming → dout and stat_o are 0 the next clock, the kernel returns to identity, and correct output resumes 7 clocks after the first post-reset column.
